bit_ser_add_ctrl: RTL and testbench
===================================

Name: bit_ser_add_ctrl

Overview:
Sequencer for the bit-serial adder datapath. Accepts a pair of parallel WIDTH-bit operands over a valid/ready handshake. Clears the adder carry, then streams the operands LSB-first for WIDTH cycles. Collects the serial sum bits plus the final carry into a (WIDTH+1)-bit result, presented on a valid/ready output handshake. Sits between a parallel requester and an external bit-serial adder instance.

Parameters:
WIDTH, 8, operand width in bits; result is WIDTH+1 bits; bit counter is clog2(WIDTH)+1 bits.

Ports:
clk  in  1  clock; all state updates on the rising edge
clr_n  in  1  asynchronous, active-low reset
in_valid  in  1  operand pair offered
in_ready  out  1  controller can accept operands
op_a  in  WIDTH  operand A (parallel)
op_b  in  WIDTH  operand B (parallel)
abort  in  1  synchronous cancel of an in-flight operation
out_valid  out  1  result available
out_ready  in  1  consumer accepts result
result  out  WIDTH+1  {carry, sum}
busy  out  1  high in CLEAR or SHIFT
add_a  out  1  serial A bit to adder
add_b  out  1  serial B bit to adder
add_en  out  1  adder carry register update enable
add_clr_n  out  1  synchronous active-low carry clear to adder
add_sum  in  1  adder combinational sum bit (add_a ^ add_b ^ carry)
add_cout  in  1  adder combinational carry-out of the current bit

Behaviour:
- Reset (clr_n=0, asynchronous): state=IDLE; in_ready=1; out_valid=0; busy=0; result=0; add_a=add_b=add_en=0; add_clr_n=1; shift registers and counter=0.
- States: IDLE, CLEAR, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1: latch op_a/op_b into shift registers, cnt=0, go to CLEAR.
- CLEAR (1 cycle):
  - add_clr_n=0, add_en=0.
  - Next state is SHIFT.
- SHIFT (exactly WIDTH cycles):
  - add_en=1; add_a=a_sh[0]; add_b=b_sh[0].
  - Each edge: sum_sh <= {add_sum, sum_sh[WIDTH-1:1]}; a_sh and b_sh shift right by one; cnt++.
  - On the edge where cnt==WIDTH-1: result <= {add_cout, add_sum, sum_sh[WIDTH-1:1]}; go to DONE.
- DONE:
  - out_valid=1; result held stable.
  - On an edge with out_ready=1, go to IDLE.
  - out_ready already high on DONE entry gives exactly one out_valid cycle.
- Latency: accept edge to out_valid = WIDTH+2 cycles. Minimum repeat interval = WIDTH+3 cycles. No IDLE bypass.
- add_a, add_b and add_en are 0 outside SHIFT. add_clr_n is 1 outside CLEAR.
- in_ready=0 outside IDLE; in_valid is ignored while not IDLE.
- abort=1 in CLEAR or SHIFT: go to IDLE next edge; result unchanged; out_valid never asserted. abort is ignored in IDLE and DONE.
- clr_n asserted mid-operation: immediate return to reset values; no partial result.
- Arithmetic is unsigned. result[WIDTH] is the carry-out of bit WIDTH-1. Overflow is impossible.
- result retains its last value after the handshake until the next completed operation.

Test Plan:
Bench instantiates a behavioural bit-serial adder (carry register with enable/clear) wired to the add_* ports.
1. op_a=7, op_b=3, out_ready=1 -> out_valid exactly 10 cycles after accept; result=9'b0_0000_1010 (10).
2. op_a=6, op_b=4 back-to-back after case 1 -> result=10; in_ready low for cycles 1..10 after accept.
3. op_a=255, op_b=255 -> result=510 (9'h1FE). Then op_a=255, op_b=1 -> result=256 (9'h100), with carry correctly cleared between operations.
4. op_a=200, op_b=100, out_ready held 0 for 5 cycles -> out_valid and result=300 stable all 5 cycles; IDLE one edge after out_ready=1.
5. op_a=0xAA, op_b=0x55; pulse abort at SHIFT cycle 3 -> IDLE next edge; out_valid stays 0; result keeps its prior value; next op 1+1 -> result=2.
6. op_a=7, op_b=3; drop clr_n at SHIFT cycle 4 -> all outputs at reset values immediately; after release, in_ready=1 and 9+9 -> result=18.

Source files
------------

// File: rtl/bit_ser_add_ctrl_if.sv
// rtl/bit_ser_add_ctrl_if.sv - operand/result handshake bundle for the bit-serial adder sequencer
`timescale 1ns/1ps

interface bit_ser_add_ctrl_if #(
    parameter int WIDTH = 8
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH:0]   result;

    // Requester / consumer side
    modport master (
        output in_valid,
        input  in_ready,
        output op_a,
        output op_b,
        input  out_valid,
        output out_ready,
        input  result
    );

    // Sequencer side
    modport slave (
        input  in_valid,
        output in_ready,
        input  op_a,
        input  op_b,
        output out_valid,
        input  out_ready,
        output result
    );
endinterface

// File: rtl/bit_ser_add_ctrl.sv
// rtl/bit_ser_add_ctrl.sv - sequencer streaming parallel operands through an external bit-serial adder
`timescale 1ns/1ps

module bit_ser_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 clr_n,
    bit_ser_add_ctrl_if.slave    bus,
    input  logic                 abort,
    output logic                 busy,
    output logic                 add_a,
    output logic                 add_b,
    output logic                 add_en,
    output logic                 add_clr_n,
    input  logic                 add_sum,
    input  logic                 add_cout
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    // Sum bits gathered so far; the last sum bit goes straight into result.
    logic [WIDTH-2:0] sum_sh;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   result_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             busy_q;
    logic             add_en_q;
    logic             add_clr_n_q;

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign busy          = busy_q;
    assign add_en        = add_en_q;
    assign add_clr_n     = add_clr_n_q;
    // Serial bits are forced low whenever the adder is not enabled.
    assign add_a         = add_en_q & a_sh[0];
    assign add_b         = add_en_q & b_sh[0];

    // Sequencer FSM with all control outputs registered alongside the state.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state       <= IDLE;
            a_sh        <= '0;
            b_sh        <= '0;
            sum_sh      <= '0;
            cnt         <= '0;
            result_q    <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            add_en_q    <= 1'b0;
            add_clr_n_q <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_sh        <= bus.op_a;
                        b_sh        <= bus.op_b;
                        cnt         <= '0;
                        state       <= CLEAR;
                        in_ready_q  <= 1'b0;
                        busy_q      <= 1'b1;
                        add_clr_n_q <= 1'b0;
                    end
                end
                CLEAR: begin
                    add_clr_n_q <= 1'b1;
                    if (abort) begin
                        state      <= IDLE;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b0;
                    end else begin
                        state    <= SHIFT;
                        add_en_q <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (abort) begin
                        state      <= IDLE;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b0;
                        add_en_q   <= 1'b0;
                    end else begin
                        sum_sh <= (WIDTH-1)'({add_sum, sum_sh} >> 1);
                        a_sh   <= a_sh >> 1;
                        b_sh   <= b_sh >> 1;
                        cnt    <= cnt + 1'b1;
                        if (cnt == CW'(WIDTH - 1)) begin
                            result_q    <= {add_cout, add_sum, sum_sh};
                            state       <= DONE;
                            add_en_q    <= 1'b0;
                            busy_q      <= 1'b0;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state       <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_bit_ser_add_ctrl.sv
// tb/tb_bit_ser_add_ctrl.sv - scoreboard bench for bit_ser_add_ctrl with a behavioural serial adder
`timescale 1ns/1ps

module tb_bit_ser_add_ctrl;
    localparam int W = 8;

    logic clk = 1'b0;
    logic clr_n = 1'b0;
    logic abort = 1'b0;
    logic busy, add_a, add_b, add_en, add_clr_n, add_sum, add_cout;
    logic carry;

    int vectors = 0;
    int miscompares = 0;
    logic [W:0] exp_q[$];

    bit_ser_add_ctrl_if #(.WIDTH(W)) bus ();

    bit_ser_add_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .clr_n     (clr_n),
        .bus       (bus),
        .abort     (abort),
        .busy      (busy),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_en    (add_en),
        .add_clr_n (add_clr_n),
        .add_sum   (add_sum),
        .add_cout  (add_cout)
    );

    always #5 clk = ~clk;

    // Behavioural bit-serial adder: one carry flop with clear and enable.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n)          carry <= 1'b0;
        else if (!add_clr_n) carry <= 1'b0;
        else if (add_en)     carry <= add_cout;
    end
    assign add_sum  = add_a ^ add_b ^ carry;
    assign add_cout = (add_a & add_b) | (carry & (add_a ^ add_b));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Pops an expected sum on every completed output handshake.
    task automatic monitor();
        forever begin
            @(negedge clk);
            #2;
            if (clr_n && bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) check("result_unexpected", 32'd1, 32'd0);
                else check("result", 32'(bus.result), 32'(exp_q.pop_front()));
            end
        end
    endtask

    // Called at a falling edge; returns at the falling edge just after the accept edge.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input bit expect_res);
        int g = 0;
        bus.op_a = a;
        bus.op_b = b;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && g < 100) begin
            @(negedge clk);
            g++;
        end
        check("accept_timeout", 32'(g >= 100), 32'd0);
        if (expect_res) exp_q.push_back((W+1)'(a) + (W+1)'(b));
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int g = 0;
        while ((exp_q.size() != 0 || !bus.in_ready) && g < 100) begin
            @(negedge clk);
            g++;
        end
        check(name, 32'(g >= 100), 32'd0);
    endtask

    initial begin
        logic [W-1:0] av;
        bit seen_valid;
        int seen_g;
        bus.in_valid  = 1'b0;
        bus.op_a      = '0;
        bus.op_b      = '0;
        bus.out_ready = 1'b1;
        fork
            monitor();
        join_none

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_result", 32'(bus.result), 32'd0);
        check("rst_add_en", 32'(add_en), 32'd0);
        check("rst_add_clr_n", 32'(add_clr_n), 32'd1);
        clr_n = 1'b1;
        @(negedge clk);

        // 7 + 3 with exact timing of every phase
        av = 8'd7;
        send(8'd7, 8'd3, 1'b1);
        check("clear_in_ready", 32'(bus.in_ready), 32'd0);
        check("clear_add_clr_n", 32'(add_clr_n), 32'd0);
        check("clear_add_en", 32'(add_en), 32'd0);
        check("clear_busy", 32'(busy), 32'd1);
        for (int k = 2; k <= 9; k++) begin
            @(negedge clk);
            check("shift_add_en", 32'(add_en), 32'd1);
            check("shift_add_a", 32'(add_a), 32'(av[k-2]));
            check("shift_out_valid", 32'(bus.out_valid), 32'd0);
            check("shift_in_ready", 32'(bus.in_ready), 32'd0);
        end
        @(negedge clk);
        check("latency_out_valid", 32'(bus.out_valid), 32'd1);
        check("done_in_ready", 32'(bus.in_ready), 32'd0);
        check("done_busy", 32'(busy), 32'd0);
        @(negedge clk);
        check("repeat_in_ready", 32'(bus.in_ready), 32'd1);

        // Back-to-back, then carry-heavy operands
        send(8'd6, 8'd4, 1'b1);
        wait_idle("timeout_b2b");
        send(8'd255, 8'd255, 1'b1);
        wait_idle("timeout_ff_ff");
        send(8'd255, 8'd1, 1'b1);
        wait_idle("timeout_ff_01");

        // Consumer back-pressure
        bus.out_ready = 1'b0;
        send(8'd200, 8'd100, 1'b1);
        seen_g = 0;
        while (!bus.out_valid && seen_g < 100) begin
            @(negedge clk);
            seen_g++;
        end
        check("timeout_stall", 32'(seen_g >= 100), 32'd0);
        for (int i = 0; i < 5; i++) begin
            check("stall_out_valid", 32'(bus.out_valid), 32'd1);
            check("stall_result", 32'(bus.result), 32'd300);
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("release_out_valid", 32'(bus.out_valid), 32'd0);
        check("release_in_ready", 32'(bus.in_ready), 32'd1);

        // Abort in SHIFT cycle 3
        send(8'hAA, 8'h55, 1'b0);
        repeat (3) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_in_ready", 32'(bus.in_ready), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_add_en", 32'(add_en), 32'd0);
        check("abort_result", 32'(bus.result), 32'd300);
        seen_valid = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (bus.out_valid) seen_valid = 1'b1;
        end
        check("abort_no_valid", 32'(seen_valid), 32'd0);
        send(8'd1, 8'd1, 1'b1);
        wait_idle("timeout_after_abort");

        // Reset in SHIFT cycle 4
        send(8'd7, 8'd3, 1'b0);
        repeat (4) @(negedge clk);
        clr_n = 1'b0;
        #1;
        check("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_add_en", 32'(add_en), 32'd0);
        check("mid_rst_add_clr_n", 32'(add_clr_n), 32'd1);
        check("mid_rst_result", 32'(bus.result), 32'd0);
        check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        clr_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
        send(8'd9, 8'd9, 1'b1);
        wait_idle("timeout_after_rst");

        // Randomized traffic with random back-pressure
        begin
            int issued = 0;
            int g = 0;
            bit pend = 1'b0;
            while (issued < 40 && g < 5000) begin
                @(negedge clk);
                g++;
                if (pend) begin
                    bus.in_valid = 1'b0;
                    pend = 1'b0;
                    issued++;
                end
                bus.out_ready = ($urandom_range(0, 3) != 0);
                if (!bus.in_valid && issued < 40 && $urandom_range(0, 1) == 1) begin
                    bus.op_a = W'($urandom);
                    bus.op_b = W'($urandom);
                    bus.in_valid = 1'b1;
                end
                if (bus.in_valid && bus.in_ready) begin
                    exp_q.push_back((W+1)'(bus.op_a) + (W+1)'(bus.op_b));
                    pend = 1'b1;
                end
            end
            check("timeout_random", 32'(g >= 5000), 32'd0);
            bus.in_valid = 1'b0;
            bus.out_ready = 1'b1;
            wait_idle("timeout_drain");
        end

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
